// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and sizing constants for the truth-table sweeper.
//   state_e : sweep controller states (IDLE, SETTLE, SAMPLE, DONE)
//   N_VARS  : number of inputs of the logic under test
//   N_ROWS  : number of truth-table rows (2**N_VARS)
//   IDX_W   : row index width
//   CNT_W   : settle counter width (covers SETTLE_CYCLES-1 up to 14)
//   MCNT_W  : mismatch counter width (covers 0..N_ROWS)
package tt_sweep_pkg;

  localparam int N_VARS = 4;
  localparam int N_ROWS = 16;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 4;
  localparam int MCNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable down-counter that holds each row stable before sampling.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val on the next edge (takes precedence over counting)
//   load_val : value to load
//   zero     : high while the count is zero
module tt_settle_timer
  import tt_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 4-input logic block through all 16 rows, holds each
// row for SETTLE_CYCLES cycles, then captures the minterm- and maxterm-form outputs.
//   clk, rst        : clock and synchronous active-high reset
//   start           : sweep request, honoured only when idle
//   a, b, c, d      : row index driven to the logic under test (a = MSB)
//   s_min, s_max    : outputs of the logic under test
//   busy, done      : sweep in progress / one-cycle end-of-sweep pulse
//   min_vec,max_vec : captured truth tables, bit k = row k
//   mismatch        : sticky, some row had s_min != s_max
//   mismatch_cnt    : number of mismatching rows
// Build option: define TT_SWEEP_MISMATCH_CNT_EN to make mismatch_cnt a live
// counter; otherwise it is tied to zero and no counter is built.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  input  logic              s_min,
  input  logic              s_max,
  output logic              busy,
  output logic              done,
  output logic [N_ROWS-1:0] min_vec,
  output logic [N_ROWS-1:0] max_vec,
  output logic              mismatch,
  output logic [MCNT_W-1:0] mismatch_cnt
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_ROWS-1:0] min_q, min_d;
  logic [N_ROWS-1:0] max_q, max_d;
  logic              mis_q, mis_d;
  logic              tmr_load;
  logic              tmr_zero;
  logic              diff;

`ifdef TT_SWEEP_MISMATCH_CNT_EN
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
`endif

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .zero     (tmr_zero)
  );

  assign diff = s_min ^ s_max;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    min_d    = min_q;
    max_d    = max_q;
    mis_d    = mis_q;
    tmr_load = 1'b0;
`ifdef TT_SWEEP_MISMATCH_CNT_EN
    mcnt_d   = mcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          idx_d    = '0;
          tmr_load = 1'b1;
          min_d    = '0;
          max_d    = '0;
          mis_d    = 1'b0;
`ifdef TT_SWEEP_MISMATCH_CNT_EN
          mcnt_d   = '0;
`endif
        end
      end
      SETTLE: begin
        if (tmr_zero) state_d = SAMPLE;
      end
      SAMPLE: begin
        min_d[idx_q] = s_min;
        max_d[idx_q] = s_max;
        mis_d        = mis_q | diff;
`ifdef TT_SWEEP_MISMATCH_CNT_EN
        mcnt_d       = mcnt_q + MCNT_W'(diff);
`endif
        // The last row leaves the index at 15; the wrap to 0 happens in DONE.
        if (idx_q == IDX_W'(N_ROWS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      mis_q   <= 1'b0;
`ifdef TT_SWEEP_MISMATCH_CNT_EN
      mcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      min_q   <= min_d;
      max_q   <= max_d;
      mis_q   <= mis_d;
`ifdef TT_SWEEP_MISMATCH_CNT_EN
      mcnt_q  <= mcnt_d;
`endif
    end
  end

  assign {a, b, c, d} = idx_q;
  assign busy         = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done         = (state_q == DONE);
  assign min_vec      = min_q;
  assign max_vec      = max_q;
  assign mismatch     = mis_q;
`ifdef TT_SWEEP_MISMATCH_CNT_EN
  assign mismatch_cnt = mcnt_q;
`else
  assign mismatch_cnt = '0;
`endif

endmodule
